// File: rtl/dw_mult_arb_pkg.sv
// Shared constants, tag type and helpers for the multiplier-sharing arbiter.
package dw_mult_arb_pkg;

    localparam int unsigned MULT_LAT = 3;

    // Sized for the largest supported requester count (16).
    localparam int unsigned ID_W = 4;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    function automatic int unsigned clog2_safe(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/DW02_mult_4_stage.sv
// Behavioural model of the DesignWare 4-stage pipelined multiplier: three register
// stages, no reset, no stall; TC selects two's-complement operands.
module DW02_mult_4_stage #(
    parameter int unsigned A_width = 8,
    parameter int unsigned B_width = 8
) (
    input  logic [A_width-1:0]         A,
    input  logic [B_width-1:0]         B,
    input  logic                       TC,
    input  logic                       CLK,
    output logic [A_width+B_width-1:0] PRODUCT
);
    localparam int unsigned P_W = A_width + B_width;

    logic [P_W-1:0] a_ext, b_ext, prod;
    logic [P_W-1:0] stage1_q, stage2_q, stage3_q;

    // Extending both operands to the full product width makes the low bits of a
    // plain multiply correct for signed and unsigned alike.
    always_comb begin
        a_ext = TC ? {{B_width{A[A_width-1]}}, A} : {{B_width{1'b0}}, A};
        b_ext = TC ? {{A_width{B[B_width-1]}}, B} : {{A_width{1'b0}}, B};
        prod  = a_ext * b_ext;
    end

    always_ff @(posedge CLK) begin
        stage1_q <= prod;
        stage2_q <= stage1_q;
        stage3_q <= stage2_q;
    end

    assign PRODUCT = stage3_q;

endmodule

// File: rtl/dw_mult_arb_rr.sv
// One-hot request arbiter with a registered round-robin pointer.
// Defining DW_MULT_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority instead.
module dw_mult_arb_rr
    import dw_mult_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt
);
`ifdef DW_MULT_ARB_FIXED_PRIO_EN
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    always_comb begin
        gnt = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (en && req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end
`else
    localparam int unsigned PTR_W = clog2_safe(NUM_REQ);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] idx;
    logic             found;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = PTR_W'((32'(ptr_q) + off) % NUM_REQ);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                ptr_d    = idx;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule

// File: rtl/dw_mult_share_arb.sv
// Shares one DW02_mult_4_stage between NUM_REQ requesters with in-order, credit-protected
// responses. Define DW_MULT_ARB_FIXED_PRIO_EN for fixed-priority arbitration.
module dw_mult_share_arb
    import dw_mult_arb_pkg::*;
#(
    parameter int unsigned A_width    = 8,
    parameter int unsigned B_width    = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*A_width-1:0]   req_a,
    input  logic [NUM_REQ*B_width-1:0]   req_b,
    input  logic [NUM_REQ-1:0]           req_tc,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   resp_id,
    output logic [A_width+B_width-1:0]   resp_product,
    output logic                         busy
);
    localparam int unsigned P_W   = A_width + B_width;
    localparam int unsigned RID_W = $clog2(NUM_REQ);
    localparam int unsigned PTR_W = clog2_safe(RESP_DEPTH);
    localparam int unsigned CNT_W = clog2_safe(RESP_DEPTH + 1);

    tag_t             tag_q [MULT_LAT];
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [RID_W-1:0] mem_id_q   [RESP_DEPTH];
    logic [P_W-1:0]   mem_prod_q [RESP_DEPTH];

    logic               pop, push, issue_ok, issue, inflight;
    logic [NUM_REQ-1:0] gnt;
    logic [RID_W-1:0]   gnt_idx;
    logic [A_width-1:0] mul_a;
    logic [B_width-1:0] mul_b;
    logic               mul_tc;
    logic [P_W-1:0]     mul_product;
    logic [ID_W-1:0]    wr_id_full;
    logic               unused_wr_id;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign resp_valid = (count_q != '0);
    assign pop        = resp_valid && resp_ready;
    assign push       = tag_q[MULT_LAT-1].vld;

    // Everything in flight already owns a FIFO slot, so the FIFO can never overflow.
    always_comb begin
        int unsigned outstanding;
        outstanding = 32'(count_q);
        for (int i = 0; i < MULT_LAT; i++) begin
            outstanding += 32'(tag_q[i].vld);
        end
        issue_ok = (outstanding < RESP_DEPTH) || pop;
    end

    dw_mult_arb_rr #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk   (CLK),
        .rst_n (rst_n),
        .req   (req_valid),
        .en    (issue_ok),
        .gnt   (gnt)
    );

    assign req_ready = gnt;
    assign issue     = |gnt;

    always_comb begin
        gnt_idx = '0;
        mul_a   = '0;
        mul_b   = '0;
        mul_tc  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = RID_W'(i);
                mul_a   = req_a[i*A_width +: A_width];
                mul_b   = req_b[i*B_width +: B_width];
                mul_tc  = req_tc[i];
            end
        end
    end

    DW02_mult_4_stage #(
        .A_width (A_width),
        .B_width (B_width)
    ) u_mult (
        .A       (mul_a),
        .B       (mul_b),
        .TC      (mul_tc),
        .CLK     (CLK),
        .PRODUCT (mul_product)
    );

    // Tag shift register mirrors the multiplier pipeline; bubbles carry vld=0.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MULT_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{vld: issue, id: ID_W'(gnt_idx)};
            for (int i = 1; i < MULT_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign wr_id_full   = tag_q[MULT_LAT-1].id;
    assign unused_wr_id = ^wr_id_full;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) begin
                mem_id_q[i]   <= '0;
                mem_prod_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_id_q[wr_ptr_q]   <= wr_id_full[RID_W-1:0];
                mem_prod_q[wr_ptr_q] <= mul_product;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst_n) begin
            assert (!(push && !pop && count_q == CNT_W'(RESP_DEPTH)));
        end
    end

    assign resp_id      = mem_id_q[rd_ptr_q];
    assign resp_product = mem_prod_q[rd_ptr_q];

    always_comb begin
        inflight = 1'b0;
        for (int i = 0; i < MULT_LAT; i++) begin
            inflight = inflight | tag_q[i].vld;
        end
    end

    assign busy = inflight || resp_valid;

endmodule

// File: tb/tb_dw_mult_share_arb.sv
// Randomized self-checking bench for dw_mult_share_arb against a transaction-queue model.
module tb_dw_mult_share_arb;
    localparam int NR    = 4;
    localparam int AW    = 8;
    localparam int BW    = 8;
    localparam int PW    = 16;
    localparam int IW    = 2;
    localparam int DEPTH = 4;
    localparam int LAT   = 3;

    logic          CLK = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req_valid, req_ready, req_tc;
    logic [NR*AW-1:0] req_a;
    logic [NR*BW-1:0] req_b;
    logic          resp_valid, resp_ready, busy;
    logic [IW-1:0] resp_id;
    logic [PW-1:0] resp_product;

    dw_mult_share_arb #(
        .A_width    (AW),
        .B_width    (BW),
        .NUM_REQ    (NR),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_tc       (req_tc),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_product (resp_product),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    // One accepted operation: who issued it, its product, and the first tick it is visible.
    typedef struct {
        int            id;
        logic [PW-1:0] prod;
        int            avail;
    } txn_t;

    txn_t q[$];
    txn_t m_head;
    int   checks = 0;
    int   failures = 0;
    int   tcyc = 0;
    int   m_ptr = NR - 1;
    logic [NR-1:0] m_gnt, s_gnt;
    logic m_rv, s_rv, m_pop, m_busy, s_busy;
    logic [IW-1:0] s_id;
    logic [PW-1:0] s_prod;

    function automatic logic [PW-1:0] ref_mult(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                               input logic tc);
        int sa, sb, p;
        sa = tc ? int'($signed(a)) : int'(a);
        sb = tc ? int'($signed(b)) : int'(b);
        p  = sa * sb;
        return p[PW-1:0];
    endfunction

    function automatic int pick(input logic [NR-1:0] v, input int ptr);
        int start;
        start = ptr;
`ifdef DW_MULT_ARB_FIXED_PRIO_EN
        start = NR - 1;
`endif
        for (int k = 1; k <= NR; k++) begin
            if (v[(start + k) % NR]) return (start + k) % NR;
        end
        return -1;
    endfunction

    // Samples DUT and model one cycle, then advances the model; no comparisons here.
    task automatic tick();
        int g;
        #1;
        tcyc++;
        m_rv   = (q.size() != 0) && (q[0].avail <= tcyc);
        m_pop  = m_rv && resp_ready;
        m_busy = (q.size() != 0);
        if (m_rv) m_head = q[0];
        g = ((q.size() < DEPTH) || m_pop) ? pick(req_valid, m_ptr) : -1;
        m_gnt  = (g >= 0) ? (NR'(1) << g) : '0;
        s_gnt  = req_ready;
        s_rv   = resp_valid;
        s_id   = resp_id;
        s_prod = resp_product;
        s_busy = busy;
        if (m_pop) void'(q.pop_front());
        if (g >= 0) begin
            q.push_back('{id: g, prod: ref_mult(req_a[g*AW +: AW], req_b[g*BW +: BW], req_tc[g]),
                          avail: tcyc + LAT + 1});
            m_ptr = g;
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < NR; i++) begin
            req_a[i*AW +: AW] = AW'($urandom);
            req_b[i*BW +: BW] = BW'($urandom);
            req_tc[i]         = 1'($urandom);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_id !== '0) begin failures++; $display("FAIL reset_resp_id got=%0d exp=0", resp_id); end
        checks++; if (resp_product !== '0) begin failures++; $display("FAIL reset_resp_product got=%h exp=0", resp_product); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single_op(input int idx, input logic [AW-1:0] a, input logic [BW-1:0] b,
                                  input logic tc, input logic [PW-1:0] exp_prod);
        int lat;
        req_valid             = NR'(1) << idx;
        req_a[idx*AW +: AW]   = a;
        req_b[idx*BW +: BW]   = b;
        req_tc[idx]           = tc;
        resp_ready            = 1'b0;
        tick();
        checks++; if (s_gnt !== (NR'(1) << idx)) begin failures++; $display("FAIL single_grant id=%0d got=%b", idx, s_gnt); end
        req_valid = '0;
        lat = 1;
        tick();
        while (!s_rv && lat < 10) begin
            tick();
            lat++;
        end
        checks++; if (lat != LAT + 1) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", lat, LAT + 1); end
        checks++; if (s_id !== IW'(idx)) begin failures++; $display("FAIL single_id got=%0d exp=%0d", s_id, idx); end
        checks++; if (s_prod !== exp_prod) begin failures++; $display("FAIL single_product got=%h exp=%h", s_prod, exp_prod); end
        checks++; if (s_busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", s_busy); end
        resp_ready = 1'b1;
        tick();
        checks++; if (s_rv !== 1'b1) begin failures++; $display("FAIL single_pop_valid got=%b exp=1", s_rv); end
        tick();
        checks++; if (s_rv !== 1'b0 || s_busy !== 1'b0) begin failures++; $display("FAIL single_idle rv=%b busy=%b exp=0/0", s_rv, s_busy); end
    endtask

    // Streams traffic against the model, then drains and confirms the DUT goes idle.
    task automatic test_traffic(input string name, input int n, input logic [NR-1:0] vmask,
                                input bit rnd_valid, input bit rnd_ready);
        for (int k = 0; k < n + 4 * DEPTH + LAT; k++) begin
            if (k >= n && q.size() == 0) break;
            randomize_ops();
            if (k < n) begin
                req_valid  = rnd_valid ? (NR'($urandom) & vmask) : vmask;
                resp_ready = rnd_ready ? 1'($urandom) : 1'b1;
            end else begin
                req_valid  = '0;
                resp_ready = 1'b1;
            end
            tick();
            checks++; if (s_gnt !== m_gnt) begin failures++; $display("FAIL %s_grant cyc=%0d got=%b exp=%b", name, tcyc, s_gnt, m_gnt); end
            checks++; if (s_rv !== m_rv) begin failures++; $display("FAIL %s_resp_valid cyc=%0d got=%b exp=%b", name, tcyc, s_rv, m_rv); end
            checks++; if (s_busy !== m_busy) begin failures++; $display("FAIL %s_busy cyc=%0d got=%b exp=%b", name, tcyc, s_busy, m_busy); end
            if (m_rv) begin
                checks++;
                if (s_id !== IW'(m_head.id) || s_prod !== m_head.prod) begin
                    failures++;
                    $display("FAIL %s_resp cyc=%0d got=%0d/%h exp=%0d/%h", name, tcyc, s_id, s_prod, m_head.id, m_head.prod);
                end
            end
        end
        checks++; if (q.size() != 0) begin failures++; $display("FAIL %s_drain left=%0d exp=0", name, q.size()); q.delete(); end
        tick();
        checks++; if (s_busy !== 1'b0 || s_rv !== 1'b0) begin failures++; $display("FAIL %s_idle busy=%b rv=%b exp=0/0", name, s_busy, s_rv); end
    endtask

    task automatic test_backpressure();
        int acc;
        acc        = 0;
        resp_ready = 1'b0;
        req_valid  = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            randomize_ops();
            tick();
            if (s_gnt != '0) acc++;
            checks++; if (s_gnt !== m_gnt) begin failures++; $display("FAIL bp_grant cyc=%0d got=%b exp=%b", tcyc, s_gnt, m_gnt); end
            if (m_rv) begin
                checks++;
                if (s_rv !== 1'b1 || s_id !== IW'(m_head.id) || s_prod !== m_head.prod) begin
                    failures++;
                    $display("FAIL bp_hold cyc=%0d got=%b/%0d/%h exp=1/%0d/%h", tcyc, s_rv, s_id, s_prod, m_head.id, m_head.prod);
                end
            end
        end
        checks++; if (acc != DEPTH) begin failures++; $display("FAIL bp_accept_count got=%0d exp=%0d", acc, DEPTH); end
        checks++; if (s_gnt !== '0) begin failures++; $display("FAIL bp_stalled got=%b exp=0", s_gnt); end
        resp_ready = 1'b1;
        randomize_ops();
        tick();
        checks++; if (s_gnt !== 4'b0001) begin failures++; $display("FAIL bp_resume got=%b exp=0001", s_gnt); end
        checks++; if (s_rv !== 1'b1 || s_prod !== m_head.prod) begin failures++; $display("FAIL bp_first_pop got=%b/%h exp=1/%h", s_rv, s_prod, m_head.prod); end
        test_traffic("bp_release", 8, 4'b0001, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midflight();
        req_valid  = 4'b0111;
        resp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            randomize_ops();
            tick();
            checks++; if (s_gnt !== m_gnt) begin failures++; $display("FAIL mid_grant cyc=%0d got=%b exp=%b", tcyc, s_gnt, m_gnt); end
        end
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin failures++; $display("FAIL mid_reset busy=%b rv=%b exp=0/0", busy, resp_valid); end
        @(negedge CLK);
        rst_n = 1'b1;
        q.delete();
        m_ptr = NR - 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (s_rv !== 1'b0 || s_busy !== 1'b0) begin failures++; $display("FAIL mid_stale cyc=%0d rv=%b busy=%b exp=0/0", tcyc, s_rv, s_busy); end
        end
        test_single_op(1, 8'd7, 8'd9, 1'b0, 16'd63);
    endtask

    initial begin
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_tc     = '0;
        resp_ready = 1'b0;
        rst_n      = 1'b0;
        test_reset();
        test_single_op(0, 8'd12, 8'd10, 1'b0, 16'd120);
        test_single_op(2, 8'hFE, 8'h05, 1'b1, 16'hFFF6);
        test_traffic("contention", 24, 4'b1111, 1'b0, 1'b0);
        test_backpressure();
        test_traffic("two_req", 12, 4'b1010, 1'b0, 1'b0);
        test_traffic("random", 300, 4'b1111, 1'b1, 1'b1);
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
